// File: rtl/hs_regfile_scoreboard.sv
// Register file with a write-pending scoreboard between decode and writeback.
// Decode stalls on RAW/WAW hazards; an optional bypass forwards same-cycle writeback data.
module hs_regfile_scoreboard #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter bit BYPASS   = 1'b1,
    parameter bit R0_ZERO  = 1'b0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                issue_req,
    output logic                issue_ack,
    input  logic [ADDR_W-1:0]   issue_rs1,
    input  logic [ADDR_W-1:0]   issue_rs2,
    input  logic [ADDR_W-1:0]   issue_rd,
    input  logic                issue_we,
    output logic [DATA_W-1:0]   rd_data1,
    output logic [DATA_W-1:0]   rd_data2,
    input  logic                wb_req,
    output logic                wb_ack,
    input  logic [ADDR_W-1:0]   wb_addr,
    input  logic [DATA_W-1:0]   wb_data,
    input  logic                wb_we,
    output logic [NUM_REGS-1:0] busy_mask,
    output logic [ADDR_W:0]     pending_cnt,
    output logic                wb_err
);

    localparam logic [ADDR_W:0] REG_LIM = (ADDR_W+1)'(NUM_REGS);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] pending_nxt;
    logic [ADDR_W:0]     cnt_nxt;

    logic wb_fire, wb_write, wb_bad, pend_wb;
    logic fwd1, fwd2, fwdd;
    logic haz1, haz2, hazd;
    logic hazard, issue_set;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < REG_LIM;
    endfunction

    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
        return R0_ZERO && (a == '0);
    endfunction

    // A "live" register is one that can hold data and be pending.
    function automatic logic live(input logic [ADDR_W-1:0] a);
        return in_range(a) && !is_zero_reg(a);
    endfunction

    assign wb_ack  = reset_n;
    assign wb_fire = wb_req & wb_ack & wb_we;

    assign fwd1 = BYPASS && wb_fire && (wb_addr == issue_rs1);
    assign fwd2 = BYPASS && wb_fire && (wb_addr == issue_rs2);
    assign fwdd = BYPASS && wb_fire && (wb_addr == issue_rd);

    assign haz1 = live(issue_rs1) && pending[issue_rs1] && !fwd1;
    assign haz2 = live(issue_rs2) && pending[issue_rs2] && !fwd2;
    assign hazd = live(issue_rd)  && pending[issue_rd]  && !fwdd;

    assign hazard    = haz1 | haz2 | (issue_we & hazd);
    assign issue_ack = reset_n & issue_req & ~hazard;
    assign issue_set = issue_ack & issue_we & live(issue_rd);

    assign pend_wb  = live(wb_addr) && pending[wb_addr];
    assign wb_write = wb_fire & live(wb_addr);
    // Writes to a hard-wired zero register are silently dropped; anything else not pending is an error.
    assign wb_bad   = wb_fire & ~is_zero_reg(wb_addr) & ~pend_wb;

    always_comb begin
        rd_data1 = '0;
        rd_data2 = '0;
        if (live(issue_rs1)) rd_data1 = fwd1 ? wb_data : regs[issue_rs1];
        if (live(issue_rs2)) rd_data2 = fwd2 ? wb_data : regs[issue_rs2];
    end

    // Clear from writeback is applied first so a same-cycle issue to that register keeps it pending.
    always_comb begin
        pending_nxt = pending;
        if (wb_write)  pending_nxt[wb_addr]  = 1'b0;
        if (issue_set) pending_nxt[issue_rd] = 1'b1;
        cnt_nxt = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            cnt_nxt = cnt_nxt + (ADDR_W+1)'(pending_nxt[i]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending     <= '0;
            pending_cnt <= '0;
            wb_err      <= 1'b0;
        end else begin
            pending     <= pending_nxt;
            pending_cnt <= cnt_nxt;
            if (wb_bad) wb_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (wb_write) begin
            regs[wb_addr] <= wb_data;
        end
    end

    assign busy_mask = pending;

endmodule

// File: tb/tb_hs_regfile_scoreboard.sv
// Scoreboard bench for hs_regfile_scoreboard: two configurations (bypass/16 regs, no-bypass/R0-zero/12 regs)
// checked cycle by cycle against an array-based reference model.
module tb_hs_regfile_scoreboard;

    localparam int DW = 16;
    localparam int AW = 4;

    logic clk;
    logic rst_n;

    logic          issue_req [2];
    logic          issue_ack [2];
    logic [AW-1:0] issue_rs1 [2];
    logic [AW-1:0] issue_rs2 [2];
    logic [AW-1:0] issue_rd  [2];
    logic          issue_we  [2];
    logic [DW-1:0] rd_data1  [2];
    logic [DW-1:0] rd_data2  [2];
    logic          wb_req    [2];
    logic          wb_ack    [2];
    logic [AW-1:0] wb_addr   [2];
    logic [DW-1:0] wb_data   [2];
    logic          wb_we     [2];
    logic [AW:0]   pend_cnt  [2];
    logic          wb_err    [2];
    logic [15:0]   busy0;
    logic [11:0]   busy1;
    logic [15:0]   busy_ext  [2];

    assign busy_ext[0] = busy0;
    assign busy_ext[1] = {4'b0000, busy1};

    hs_regfile_scoreboard #(.DATA_W(DW), .NUM_REGS(16), .BYPASS(1'b1), .R0_ZERO(1'b0)) u0 (
        .clk(clk), .reset_n(rst_n),
        .issue_req(issue_req[0]), .issue_ack(issue_ack[0]),
        .issue_rs1(issue_rs1[0]), .issue_rs2(issue_rs2[0]), .issue_rd(issue_rd[0]), .issue_we(issue_we[0]),
        .rd_data1(rd_data1[0]), .rd_data2(rd_data2[0]),
        .wb_req(wb_req[0]), .wb_ack(wb_ack[0]), .wb_addr(wb_addr[0]), .wb_data(wb_data[0]), .wb_we(wb_we[0]),
        .busy_mask(busy0), .pending_cnt(pend_cnt[0]), .wb_err(wb_err[0])
    );

    hs_regfile_scoreboard #(.DATA_W(DW), .NUM_REGS(12), .BYPASS(1'b0), .R0_ZERO(1'b1)) u1 (
        .clk(clk), .reset_n(rst_n),
        .issue_req(issue_req[1]), .issue_ack(issue_ack[1]),
        .issue_rs1(issue_rs1[1]), .issue_rs2(issue_rs2[1]), .issue_rd(issue_rd[1]), .issue_we(issue_we[1]),
        .rd_data1(rd_data1[1]), .rd_data2(rd_data2[1]),
        .wb_req(wb_req[1]), .wb_ack(wb_ack[1]), .wb_addr(wb_addr[1]), .wb_data(wb_data[1]), .wb_we(wb_we[1]),
        .busy_mask(busy1), .pending_cnt(pend_cnt[1]), .wb_err(wb_err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Configuration of each instance, as seen by the model.
    int nregs [2] = '{16, 12};
    bit byp   [2] = '{1'b1, 1'b0};
    bit r0z   [2] = '{1'b0, 1'b1};

    // Reference model state.
    logic [DW-1:0] m_regs [2][16];
    bit            m_pend [2][16];
    bit            m_err  [2];
    bit            last_ack [2];

    typedef struct {
        int          k;
        int          cyc;
        bit          ack;
        bit          wback;
        bit          chk_rd;
        logic [15:0] d1;
        logic [15:0] d2;
        logic [15:0] busy;
        int          cnt;
        bit          err;
    } exp_t;

    exp_t sbq[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    function automatic bit live(int k, int a);
        return (a < nregs[k]) && !(r0z[k] && a == 0);
    endfunction

    function automatic bit wfire(int k);
        return rst_n && wb_req[k] && wb_we[k];
    endfunction

    function automatic bit fwd(int k, int a);
        return byp[k] && wfire(k) && (int'(wb_addr[k]) == a);
    endfunction

    function automatic bit haz(int k, int a);
        return live(k, a) && m_pend[k][a] && !fwd(k, a);
    endfunction

    function automatic logic [15:0] rdval(int k, int a);
        if (!live(k, a)) return 16'h0000;
        if (fwd(k, a))   return wb_data[k];
        return m_regs[k][a];
    endfunction

    task automatic model_reset(int k);
        for (int i = 0; i < 16; i++) begin
            m_regs[k][i] = '0;
            m_pend[k][i] = 1'b0;
        end
        m_err[k]    = 1'b0;
        last_ack[k] = 1'b0;
    endtask

    // Expected outputs for the inputs currently applied, queued for the monitor.
    task automatic expect_push();
        for (int k = 0; k < 2; k++) begin
            exp_t e;
            e.k = k;
            e.cyc = cyc;
            if (!rst_n) begin
                model_reset(k);
                e.ack = 0; e.wback = 0; e.chk_rd = 1; e.d1 = '0; e.d2 = '0;
                e.busy = '0; e.cnt = 0; e.err = 0;
            end else begin
                int a1 = int'(issue_rs1[k]);
                int a2 = int'(issue_rs2[k]);
                int ad = int'(issue_rd[k]);
                e.ack = issue_req[k] && !(haz(k, a1) || haz(k, a2) || (issue_we[k] && haz(k, ad)));
                e.wback = 1;
                e.chk_rd = e.ack;
                e.d1 = rdval(k, a1);
                e.d2 = rdval(k, a2);
                e.busy = '0;
                e.cnt = 0;
                for (int i = 0; i < 16; i++) begin
                    e.busy[i] = m_pend[k][i];
                    e.cnt += int'(m_pend[k][i]);
                end
                e.err = m_err[k];
            end
            last_ack[k] = e.ack;
            sbq.push_back(e);
        end
    endtask

    task automatic model_update();
        if (!rst_n) return;
        for (int k = 0; k < 2; k++) begin
            int wa = int'(wb_addr[k]);
            int ad = int'(issue_rd[k]);
            if (wfire(k)) begin
                if (live(k, wa)) begin
                    if (!m_pend[k][wa]) m_err[k] = 1'b1;
                    m_regs[k][wa] = wb_data[k];
                    m_pend[k][wa] = 1'b0;
                end else if (wa >= nregs[k]) begin
                    m_err[k] = 1'b1;
                end
            end
            if (last_ack[k] && issue_we[k] && live(k, ad)) m_pend[k][ad] = 1'b1;
        end
    endtask

    task automatic cycle();
        expect_push();
        @(posedge clk);
        model_update();
        cyc++;
        #1;
    endtask

    task automatic set_all(bit ireq, int r1, int r2, int rdd, bit iwe, bit wreq, int wa, int wd, bit wwe);
        for (int k = 0; k < 2; k++) begin
            issue_req[k] = ireq;
            issue_rs1[k] = AW'(r1);
            issue_rs2[k] = AW'(r2);
            issue_rd[k]  = AW'(rdd);
            issue_we[k]  = iwe;
            wb_req[k]    = wreq;
            wb_addr[k]   = AW'(wa);
            wb_data[k]   = DW'(wd);
            wb_we[k]     = wwe;
        end
    endtask

    task automatic chk(string name, int k, int c, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s inst%0d cycle %0d: got %h expected %h", name, k, c, act, exp);
        end
    endtask

    // Monitor: outputs are sampled on the falling edge, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            while (sbq.size() > 0) begin
                exp_t e;
                int k;
                e = sbq.pop_front();
                k = e.k;
                chk("issue_ack", k, e.cyc, 32'(issue_ack[k]), 32'(e.ack));
                chk("wb_ack", k, e.cyc, 32'(wb_ack[k]), 32'(e.wback));
                chk("busy_mask", k, e.cyc, 32'(busy_ext[k]), 32'(e.busy));
                chk("pending_cnt", k, e.cyc, 32'(pend_cnt[k]), 32'(e.cnt));
                chk("wb_err", k, e.cyc, 32'(wb_err[k]), 32'(e.err));
                if (e.chk_rd) begin
                    chk("rd_data1", k, e.cyc, 32'(rd_data1[k]), 32'(e.d1));
                    chk("rd_data2", k, e.cyc, 32'(rd_data2[k]), 32'(e.d2));
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        set_all(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        repeat (3) cycle();
        rst_n = 1'b1;

        // Fresh read after reset
        set_all(1, 3, 5, 0, 0, 0, 0, 0, 0); cycle();
        // RAW stall on r4, released by writeback of 0x1234
        set_all(1, 1, 1, 4, 1, 0, 0, 0, 0); cycle();
        set_all(1, 4, 0, 0, 0, 0, 0, 0, 0); cycle(); cycle();
        set_all(1, 4, 0, 0, 0, 1, 4, 'h1234, 1); cycle();
        set_all(1, 4, 0, 0, 0, 0, 0, 0, 0); cycle();
        set_all(0, 0, 0, 0, 0, 0, 0, 0, 0); cycle();
        // Same-register clear/set on r7
        set_all(1, 0, 0, 7, 1, 0, 0, 0, 0); cycle();
        set_all(1, 0, 0, 7, 1, 1, 7, 'hbeef, 1); cycle();
        set_all(1, 0, 0, 7, 1, 0, 0, 0, 0); cycle();
        set_all(0, 0, 0, 0, 0, 1, 7, 'h0007, 1); cycle();
        set_all(1, 7, 0, 0, 0, 0, 0, 0, 0); cycle();
        // Write to r0, then read it back
        set_all(0, 0, 0, 0, 0, 1, 0, 'hffff, 1); cycle();
        set_all(1, 0, 0, 0, 0, 0, 0, 0, 0); cycle();
        // Write to non-pending r9; error must stay set
        set_all(0, 0, 0, 0, 0, 1, 9, 'h55aa, 1); cycle();
        set_all(1, 9, 9, 0, 0, 0, 0, 0, 0); cycle(); cycle();
        // Out-of-range address for the 12-entry instance
        rst_n = 1'b0; set_all(0, 0, 0, 0, 0, 0, 0, 0, 0); cycle();
        rst_n = 1'b1;
        set_all(0, 0, 0, 0, 0, 1, 13, 'h1313, 1); cycle();
        set_all(1, 13, 13, 13, 1, 0, 0, 0, 0); cycle(); cycle();
        // Reset with r2, r6 outstanding, then read every register
        set_all(1, 0, 0, 2, 1, 0, 0, 0, 0); cycle();
        set_all(1, 0, 0, 6, 1, 0, 0, 0, 0); cycle();
        rst_n = 1'b0; set_all(0, 0, 0, 0, 0, 0, 0, 0, 0); cycle();
        rst_n = 1'b1;
        for (int r = 0; r < 16; r++) begin
            set_all(1, r, 15 - r, 0, 0, 0, 0, 0, 0);
            cycle();
        end

        // Randomized traffic; issue fields are held until accepted
        for (int c = 0; c < 4000; c++) begin
            rst_n = (c % 700 != 699);
            for (int k = 0; k < 2; k++) begin
                int pl[$];
                if (!(issue_req[k] && !last_ack[k])) begin
                    issue_req[k] = ($urandom_range(0, 9) < 7);
                    issue_rs1[k] = AW'($urandom_range(0, 15));
                    issue_rs2[k] = AW'($urandom_range(0, 15));
                    issue_rd[k]  = AW'($urandom_range(0, 15));
                    issue_we[k]  = ($urandom_range(0, 9) < 7);
                end
                for (int i = 0; i < 16; i++) if (m_pend[k][i]) pl.push_back(i);
                wb_req[k]  = ($urandom_range(0, 9) < 6);
                wb_we[k]   = ($urandom_range(0, 19) != 0);
                wb_data[k] = DW'($urandom);
                if (pl.size() > 0 && $urandom_range(0, 39) != 0)
                    wb_addr[k] = AW'(pl[$urandom_range(0, pl.size() - 1)]);
                else
                    wb_addr[k] = AW'($urandom_range(0, 15));
            end
            cycle();
        end

        rst_n = 1'b1;
        set_all(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        @(negedge clk);
        #1;
        chk("queue_drained", 0, cyc, 32'(sbq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
